board_writer: RTL
=================

BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, cells packed per memory word.
REQ-002 SHALL have parameter LOG_MAX_ADDR, default 12, board memory address width.
REQ-003 SHALL have parameter NUM_WORDS, default 4096, words per board generation.
REQ-004 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start_in  input  1  begin writing one generation.
REQ-007 SHALL have port cell_in  input  1  next-state bit of current cell.
REQ-008 SHALL have port cell_valid_in  input  1  cell_in valid.
REQ-009 SHALL have port cell_ready_out  output  1  block accepts cell this cycle.
REQ-010 SHALL have port addr_w_out  output  LOG_MAX_ADDR  write address.
REQ-011 SHALL have port data_w_out  output  WORD_SIZE  write data.
REQ-012 SHALL have port we_out  output  1  write enable, one cycle per word.
REQ-013 SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done_out  output  1  one-cycle pulse when the generation is complete.

Function
REQ-015 SHALL implement states IDLE, PACK, WRITE, DONE (plus CLEAR per REQ-029).
REQ-016 IDLE: start_in=1 -> PACK next cycle; word address cleared to 0; shift register and bit counter cleared to 0.
REQ-017 cell_ready_out SHALL be 1 only in PACK; a cell is accepted iff cell_valid_in&&cell_ready_out; cells offered in other states are ignored.
REQ-018 Bit order SHALL be LSB-first: the k-th accepted cell of a word (k=0..WORD_SIZE-1) lands in data bit k.
REQ-019 The cycle after the WORD_SIZE-th accept, the block SHALL be in WRITE with we_out=1, addr_w_out=current word address, and data_w_out=the packed word, for exactly one cycle.
REQ-020 From WRITE: if the address is NUM_WORDS-1 -> DONE; else increment the address, clear the bit counter, -> PACK.
REQ-021 DONE SHALL assert done_out for one cycle, then -> IDLE; busy_out=0 from that IDLE cycle on.
REQ-022 start_in while busy_out=1 SHALL be ignored.
REQ-023 Address arithmetic SHALL be unsigned, LOG_MAX_ADDR bits; the address never exceeds NUM_WORDS-1.
REQ-024 we_out=0 in all states except WRITE and CLEAR; data_w_out and addr_w_out hold their last value when we_out=0.
REQ-025 Throughput SHALL be one word per WORD_SIZE+1 cycles under continuous cell_valid_in.

Reset
REQ-026 rst_n_in=0 at a clock edge SHALL force IDLE and zero every output, address, counter and shift register.
REQ-027 Reset mid-generation SHALL abort with no further we_out and no done_out; the next start_in begins again at address 0.

Configuration
REQ-028 Macro BOARD_WRITER_CLEAR_EN SHALL control the clear feature.
REQ-029 With the macro defined, port clear_in (input, 1) SHALL exist. clear_in in IDLE -> CLEAR, which writes data 0 to addresses 0..NUM_WORDS-1 at one word per cycle (we_out=1 throughout), then -> DONE.
REQ-030 With the macro defined, clear_in and start_in asserted together in IDLE SHALL select clear; clear_in while busy_out=1 is ignored.
REQ-031 Without the macro, the clear_in port and the CLEAR state SHALL be absent; all other behaviour is identical.

Structure
REQ-032 WORD_SIZE, LOG_MAX_ADDR and the state enum typedef SHALL live in the shared common package/header.
REQ-033 Shift register and bit counter SHALL be a sub-module named word_packer (inputs: shift enable, clear; outputs: word, full flag).

Verification (WORD_SIZE=16, NUM_WORDS=4)
REQ-034 Hold rst_n_in=0 for 1 cycle -> all outputs 0; state is IDLE; cell_ready_out=0.
REQ-035 start_in, then 16 cells 1,0,0,...,0,1 -> one cycle after the 16th accept: we_out=1, addr_w_out=0, data_w_out=16'h8001.
REQ-036 cell_valid_in toggled every other cycle -> same data; cell_ready_out=0 during the WRITE cycle; no cells lost or duplicated.
REQ-037 64 cells streamed continuously -> writes to addresses 0,1,2,3 exactly 17 cycles apart; done_out pulses the cycle after the last write; a start_in during the run has no effect.
REQ-038 rst_n_in=0 after 7 accepts -> no we_out and no done_out; a new start plus 16 cells -> write to addr 0 containing only the new cells.
REQ-039 With BOARD_WRITER_CLEAR_EN: clear_in and start_in asserted together -> 4 consecutive we_out cycles, addresses 0..3, data 0, then a done_out pulse.

Source files
------------

// File: rtl/board_writer_pkg.sv
// Shared sizing defaults and FSM state encoding for the board writer.
// Optional clear feature: BOARD_WRITER_CLEAR_EN adds the CLEAR state.
package board_writer_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int LOG_MAX_ADDR = 12;
  localparam int NUM_WORDS    = 4096;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PACK  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef BOARD_WRITER_CLEAR_EN
    ,
    S_CLEAR = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/board_writer_word_packer.sv
// LSB-first shift register and cell counter that assembles one memory word.
module word_packer #(
  parameter int WORD_SIZE = board_writer_pkg::WORD_SIZE
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 shift_en_in,
  input  logic                 clear_in,
  input  logic                 cell_in,
  output logic [WORD_SIZE-1:0] word_out,
  output logic                 full_out
);

  localparam int CW = $clog2(WORD_SIZE + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || clear_in) begin
      word_out <= '0;
      count_q  <= '0;
    end else if (shift_en_in) begin
      // New cells enter at the top so the first cell ends up in bit 0.
      word_out <= {cell_in, word_out[WORD_SIZE-1:1]};
      count_q  <= count_q + 1'b1;
    end
  end

  // Word holds WORD_SIZE-1 cells: the next accepted cell completes it.
  assign full_out = (count_q == CW'(WORD_SIZE - 1));

endmodule

// File: rtl/board_writer.sv
// Packs a stream of cell bits into words and writes one board generation.
// Optional clear feature: BOARD_WRITER_CLEAR_EN adds clear_in and CLEAR.
module board_writer
  import board_writer_pkg::*;
#(
  parameter int WORD_SIZE    = board_writer_pkg::WORD_SIZE,
  parameter int LOG_MAX_ADDR = board_writer_pkg::LOG_MAX_ADDR,
  parameter int NUM_WORDS    = board_writer_pkg::NUM_WORDS
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
`ifdef BOARD_WRITER_CLEAR_EN
  input  logic                    clear_in,
`endif
  input  logic                    cell_in,
  input  logic                    cell_valid_in,
  output logic                    cell_ready_out,
  output logic [LOG_MAX_ADDR-1:0] addr_w_out,
  output logic [WORD_SIZE-1:0]    data_w_out,
  output logic                    we_out,
  output logic                    busy_out,
  output logic                    done_out,
  output state_t                  state_out
);

  // Cell handshake: a cell transfers on a rising edge where cell_valid_in and
  // cell_ready_out are both high; ready is high only while packing.

  localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR = LOG_MAX_ADDR'(NUM_WORDS - 1);

  state_t                  state_q;
  logic [LOG_MAX_ADDR-1:0] addr_q;
  logic [WORD_SIZE-1:0]    packed_word;
  logic [WORD_SIZE-1:0]    next_word;
  logic                    pack_full;
  logic                    pack_clear;
  logic                    accept;

  assign cell_ready_out = (state_q == S_PACK);
  assign accept         = cell_valid_in && cell_ready_out;
  assign pack_clear     = (state_q == S_IDLE) || (state_q == S_WRITE);
  assign next_word      = {cell_in, packed_word[WORD_SIZE-1:1]};
  assign busy_out       = (state_q != S_IDLE);
  assign state_out      = state_q;

  word_packer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_packer (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .shift_en_in (accept),
    .clear_in    (pack_clear),
    .cell_in     (cell_in),
    .word_out    (packed_word),
    .full_out    (pack_full)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      addr_w_out <= '0;
      data_w_out <= '0;
      we_out     <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state_q)
        S_IDLE: begin
          we_out <= 1'b0;
`ifdef BOARD_WRITER_CLEAR_EN
          if (clear_in) begin
            state_q    <= S_CLEAR;
            addr_q     <= '0;
            addr_w_out <= '0;
            data_w_out <= '0;
            we_out     <= 1'b1;
          end else
`endif
          if (start_in) begin
            state_q <= S_PACK;
            addr_q  <= '0;
          end
        end
        S_PACK: begin
          // The completing cell is folded in here so the write issues next cycle.
          if (accept && pack_full) begin
            state_q    <= S_WRITE;
            we_out     <= 1'b1;
            addr_w_out <= addr_q;
            data_w_out <= next_word;
          end
        end
        S_WRITE: begin
          we_out <= 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_q  <= S_DONE;
            done_out <= 1'b1;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= S_PACK;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
`ifdef BOARD_WRITER_CLEAR_EN
        S_CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            we_out   <= 1'b0;
            done_out <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            addr_q     <= addr_q + 1'b1;
            addr_w_out <= addr_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
